// File: rtl/nf10_axis_loopback_port.sv
// Store-and-forward AXI-Stream loopback: buffers whole packets, swaps tuser src/dst ports and replays them.
// Define LOOPBACK_STATS_EN to add saturating pkt_count / drop_count outputs.
module nf10_axis_loopback_port #(
  parameter int C_DATA_WIDTH      = 64,
  parameter int C_TUSER_WIDTH     = 128,
  parameter int C_FIFO_DEPTH_LOG2 = 9,
  parameter int C_HDR_DEPTH_LOG2  = 4
) (
  input  logic                      axi_aclk,
  input  logic                      axi_resetn,

  input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axis_tstrb,
  input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,

  output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0] m_axis_tstrb,
  output logic [C_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      m_axis_tlast
`ifdef LOOPBACK_STATS_EN
  ,
  output logic [31:0]               pkt_count,
  output logic [31:0]               drop_count
`endif
);

  localparam int STRB_W     = C_DATA_WIDTH / 8;
  localparam int ENTRY_W    = 1 + STRB_W + C_DATA_WIDTH;
  localparam int FIFO_DEPTH = 1 << C_FIFO_DEPTH_LOG2;
  localparam int HDR_DEPTH  = 1 << C_HDR_DEPTH_LOG2;
  localparam int PTR_W      = C_FIFO_DEPTH_LOG2 + 1;
  localparam int HPTR_W     = C_HDR_DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {S_IDLE, S_PKT, S_DROP, S_COMMIT} in_state_e;
  typedef enum logic       {S_OIDLE, S_OSEND}                out_state_e;

  // Storage
  logic [ENTRY_W-1:0]       r_data_mem [FIFO_DEPTH];
  logic [C_TUSER_WIDTH-1:0] r_hdr_mem  [HDR_DEPTH];

  // Input side
  in_state_e                r_in_state;
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_commit_ptr;
  logic [C_TUSER_WIDTH-1:0] r_hdr_reg;
  logic                     r_s_tready;

  // Header FIFO bookkeeping
  logic [HPTR_W-1:0]        r_hdr_wr_ptr;
  logic [HPTR_W-1:0]        r_hdr_rd_ptr;
  logic [HPTR_W-1:0]        r_pkt_pending;

  // Output side
  out_state_e               r_out_state;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [C_DATA_WIDTH-1:0]  r_m_tdata;
  logic [STRB_W-1:0]        r_m_tstrb;
  logic [C_TUSER_WIDTH-1:0] r_m_tuser;
  logic                     r_m_tvalid;
  logic                     r_m_tlast;

  logic                     w_buf_full;
  logic                     w_hdr_empty;
  logic                     w_s_fire;
  logic                     w_accepting;
  logic                     w_wr_en;
  logic                     w_overflow;
  logic                     w_hdr_push;
  logic                     w_hdr_pop;
  logic                     w_m_fire;
  logic                     w_pkt_done;
  logic [HPTR_W-1:0]        w_pending_nxt;
  logic                     w_hdr_full_nxt;
  logic [C_TUSER_WIDTH-1:0] w_swapped_user;

  assign w_buf_full  = (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0]) &&
                       (r_wr_ptr[PTR_W-1]   != r_rd_ptr[PTR_W-1]);
  assign w_hdr_empty = (r_hdr_wr_ptr == r_hdr_rd_ptr);

  assign w_s_fire    = s_axis_tvalid & r_s_tready;
  assign w_accepting = (r_in_state == S_IDLE) || (r_in_state == S_PKT);
  assign w_wr_en     = w_s_fire && w_accepting && !w_buf_full;
  assign w_overflow  = w_s_fire && w_accepting &&  w_buf_full;

  assign w_hdr_push  = (r_in_state == S_COMMIT);
  assign w_hdr_pop   = (r_out_state == S_OIDLE) && !w_hdr_empty;
  assign w_m_fire    = r_m_tvalid & m_axis_tready;
  assign w_pkt_done  = w_m_fire & r_m_tlast;

  // A header slot stays reserved until its packet has fully left, so at most
  // HDR_DEPTH packets are outstanding including the one being transmitted.
  assign w_pending_nxt  = r_pkt_pending + HPTR_W'(w_hdr_push) - HPTR_W'(w_pkt_done);
  assign w_hdr_full_nxt = (w_pending_nxt == HPTR_W'(HDR_DEPTH));

  assign w_swapped_user = {s_axis_tuser[C_TUSER_WIDTH-1:32],
                           s_axis_tuser[23:16],
                           s_axis_tuser[31:24],
                           s_axis_tuser[15:0]};

  // NOTE: storage arrays carry no reset so they map onto RAM; pointers alone define what is valid.
  always_ff @(posedge axi_aclk) begin
    if (w_wr_en)
      r_data_mem[r_wr_ptr[PTR_W-2:0]] <= {s_axis_tlast, s_axis_tstrb, s_axis_tdata};
    if (w_hdr_push)
      r_hdr_mem[r_hdr_wr_ptr[HPTR_W-2:0]] <= r_hdr_reg;
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_in_state   <= S_IDLE;
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_hdr_reg    <= '0;
      r_s_tready   <= 1'b0;
    end else begin
      case (r_in_state)
        S_IDLE: begin
          r_s_tready <= !w_hdr_full_nxt;
          if (w_s_fire) begin
            r_hdr_reg <= w_swapped_user;
            if (w_buf_full) begin
              // A full buffer on the first beat drops the packet; one-beat packets end right here.
              if (!s_axis_tlast) begin
                r_in_state <= S_DROP;
                r_s_tready <= 1'b1;
              end
            end else begin
              r_wr_ptr <= r_wr_ptr + PTR_W'(1);
              if (s_axis_tlast) begin
                r_in_state <= S_COMMIT;
                r_s_tready <= 1'b0;
              end else begin
                r_in_state <= S_PKT;
                r_s_tready <= 1'b1;
              end
            end
          end
        end

        S_PKT: begin
          if (w_s_fire) begin
            if (w_buf_full) begin
              r_wr_ptr <= r_commit_ptr;
              if (s_axis_tlast) begin
                r_in_state <= S_IDLE;
                r_s_tready <= !w_hdr_full_nxt;
              end else begin
                r_in_state <= S_DROP;
              end
            end else begin
              r_wr_ptr <= r_wr_ptr + PTR_W'(1);
              if (s_axis_tlast) begin
                r_in_state <= S_COMMIT;
                r_s_tready <= 1'b0;
              end
            end
          end
        end

        S_DROP: begin
          if (w_s_fire && s_axis_tlast) begin
            r_in_state <= S_IDLE;
            r_s_tready <= !w_hdr_full_nxt;
          end
        end

        S_COMMIT: begin
          r_commit_ptr <= r_wr_ptr;
          r_in_state   <= S_IDLE;
          r_s_tready   <= !w_hdr_full_nxt;
        end

        default: begin
          r_in_state <= S_IDLE;
          r_s_tready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_hdr_wr_ptr  <= '0;
      r_pkt_pending <= '0;
    end else begin
      if (w_hdr_push)
        r_hdr_wr_ptr <= r_hdr_wr_ptr + HPTR_W'(1);
      r_pkt_pending <= w_pending_nxt;
    end
  end

  // The output register doubles as the RAM read register: a new entry is
  // fetched only when the current beat is accepted, so a stall holds everything.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_out_state  <= S_OIDLE;
      r_rd_ptr     <= '0;
      r_hdr_rd_ptr <= '0;
      r_m_tdata    <= '0;
      r_m_tstrb    <= '0;
      r_m_tuser    <= '0;
      r_m_tvalid   <= 1'b0;
      r_m_tlast    <= 1'b0;
    end else begin
      case (r_out_state)
        S_OIDLE: begin
          if (w_hdr_pop) begin
            r_m_tuser    <= r_hdr_mem[r_hdr_rd_ptr[HPTR_W-2:0]];
            r_hdr_rd_ptr <= r_hdr_rd_ptr + HPTR_W'(1);
            {r_m_tlast, r_m_tstrb, r_m_tdata} <= r_data_mem[r_rd_ptr[PTR_W-2:0]];
            r_rd_ptr     <= r_rd_ptr + PTR_W'(1);
            r_m_tvalid   <= 1'b1;
            r_out_state  <= S_OSEND;
          end
        end

        S_OSEND: begin
          if (w_m_fire) begin
            if (r_m_tlast) begin
              r_m_tvalid  <= 1'b0;
              r_out_state <= S_OIDLE;
            end else begin
              {r_m_tlast, r_m_tstrb, r_m_tdata} <= r_data_mem[r_rd_ptr[PTR_W-2:0]];
              r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
          end
        end

        default: begin
          r_out_state <= S_OIDLE;
          r_m_tvalid  <= 1'b0;
        end
      endcase
    end
  end

  assign s_axis_tready = r_s_tready;
  assign m_axis_tdata  = r_m_tdata;
  assign m_axis_tstrb  = r_m_tstrb;
  assign m_axis_tuser  = r_m_tuser;
  assign m_axis_tvalid = r_m_tvalid;
  assign m_axis_tlast  = r_m_tlast;

`ifdef LOOPBACK_STATS_EN
  logic [31:0] r_pkt_count;
  logic [31:0] r_drop_count;

  // w_overflow fires exactly once per dropped packet, since the FSM leaves the accepting states on it.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_pkt_count  <= '0;
      r_drop_count <= '0;
    end else begin
      if (w_hdr_push && (r_pkt_count != 32'hFFFF_FFFF))
        r_pkt_count <= r_pkt_count + 32'd1;
      if (w_overflow && (r_drop_count != 32'hFFFF_FFFF))
        r_drop_count <= r_drop_count + 32'd1;
    end
  end

  assign pkt_count  = r_pkt_count;
  assign drop_count = r_drop_count;
`endif

endmodule

// File: tb/tb_nf10_axis_loopback_port.sv
// Self-checking bench for nf10_axis_loopback_port: header-rewrite vector table plus
// scoreboard-checked overflow, backpressure, header-full and mid-packet reset sequences.
module tb_nf10_axis_loopback_port;

  typedef struct packed {
    logic [63:0]  data;
    logic [7:0]   strb;
    logic         last;
    logic [127:0] user;
  } beat_t;

  typedef struct {
    logic [31:0] user_lo;
    int          n_beats;
    logic [7:0]  strb;
    logic [31:0] exp_lo;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic [63:0]  s_axis_tdata = '0;
  logic [7:0]   s_axis_tstrb = '0;
  logic [127:0] s_axis_tuser = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic         s_axis_tlast = 1'b0;

  logic [63:0]  m_axis_tdata;
  logic [7:0]   m_axis_tstrb;
  logic [127:0] m_axis_tuser;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast;
`ifdef LOOPBACK_STATS_EN
  logic [31:0]  pkt_count;
  logic [31:0]  drop_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;

  beat_t        sb[$];
  beat_t        exp_b;
  logic         prev_stall = 1'b0;
  logic [201:0] held = '0;

  always #5 clk = ~clk;

  nf10_axis_loopback_port dut (
    .axi_aclk      (clk),
    .axi_resetn    (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tstrb  (s_axis_tstrb),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tstrb  (m_axis_tstrb),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast)
`ifdef LOOPBACK_STATS_EN
    ,
    .pkt_count     (pkt_count),
    .drop_count    (drop_count)
`endif
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] swap_ports(input logic [31:0] u);
    return {u[23:16], u[31:24], u[15:0]};
  endfunction

  // Output monitor: samples on the falling edge, when both DUT outputs and m_axis_tready are settled.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata, m_axis_tuser}, held);
      if (m_axis_tvalid && m_axis_tready) begin
        n_out++;
        check("sb_has_entry", sb.size() != 0, 1'b1);
        if (sb.size() != 0) begin
          exp_b = sb.pop_front();
          check("out_tdata", m_axis_tdata, exp_b.data);
          check("out_tstrb", m_axis_tstrb, exp_b.strb);
          check("out_tlast", m_axis_tlast, exp_b.last);
          check("out_tuser", m_axis_tuser, exp_b.user);
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      held = {m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tdata, m_axis_tuser};
    end
  end

  // Drives one beat from posedge+1 and returns posedge+1 after it was accepted.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic [127:0] u, input logic l);
    int n;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tstrb  = s;
    s_axis_tuser  = u;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!s_axis_tready) begin
      check("s_tready_wait", s_axis_tready, 1'b1);
    end else begin
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input logic [31:0] user_lo, input int n, input logic [7:0] strb,
                          input logic [31:0] exp_lo, input bit deliver);
    logic [95:0]  hi;
    logic [127:0] u;
    beat_t        b;
    hi = {$urandom, $urandom, $urandom};
    for (int i = 0; i < n; i++) begin
      b.data = {$urandom, $urandom};
      b.strb = strb;
      b.last = (i == n - 1);
      b.user = {hi, exp_lo};
      if (deliver) sb.push_back(b);
      u = (i == 0) ? {hi, user_lo} : {$urandom, $urandom, $urandom, $urandom};
      send_beat(b.data, strb, u, b.last);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_axis_tvalid) && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, sb.size(), 0);
    repeat (10) @(posedge clk);
    #1;
  endtask

  vec_t vecs[6];

  initial begin
    int base;
    int total;

    vecs[0] = '{32'h0104_0040, 8, 8'hFF, 32'h0401_0040};
    vecs[1] = '{32'h0203_0008, 1, 8'h0F, 32'h0302_0008};
    vecs[2] = '{32'h0506_0008, 1, 8'h0F, 32'h0605_0008};
    vecs[3] = '{32'h0708_0010, 1, 8'h0F, 32'h0807_0010};
    vecs[4] = '{32'hABCD_1234, 3, 8'h3C, 32'hCDAB_1234};
    vecs[5] = '{32'h00FF_FFFF, 2, 8'h01, 32'hFF00_FFFF};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_tready", s_axis_tready, 1'b0);
    check("rst_m_tvalid", m_axis_tvalid, 1'b0);
    check("rst_m_tdata",  m_axis_tdata,  64'h0);
    check("rst_m_tuser",  m_axis_tuser,  128'h0);
    check("rst_m_tlast",  m_axis_tlast,  1'b0);
    check("rst_m_tstrb",  m_axis_tstrb,  8'h0);
    rst_n = 1'b1;
    check("post_rel_s_tready", s_axis_tready, 1'b0);
    @(posedge clk); #1;
    check("first_clk_s_tready", s_axis_tready, 1'b1);

    // Header rewrite vectors, back to back
    m_axis_tready = 1'b1;
    base  = n_out;
    total = 0;
    for (int i = 0; i < 6; i++) begin
      send_pkt(vecs[i].user_lo, vecs[i].n_beats, vecs[i].strb, vecs[i].exp_lo, 1'b1);
      total += vecs[i].n_beats;
      if (i == 0) begin
        check("latency_tlast_plus0", m_axis_tvalid, 1'b0);
        @(posedge clk); #1;
        check("latency_tlast_plus1", m_axis_tvalid, 1'b0);
      end
    end
    wait_drain("vec_drained");
    check("vec_beat_count", n_out - base, total);

    // Oversized packet dropped whole; following packet intact
    base = n_out;
    send_pkt(32'h0102_0258, 600, 8'hFF, 32'h0201_0258, 1'b0);
    send_pkt(32'h0506_0020, 4, 8'hFF, 32'h0605_0020, 1'b1);
    wait_drain("ovf_drained");
    check("ovf_beat_count", n_out - base, 4);
`ifdef LOOPBACK_STATS_EN
    check("ovf_drop_count", drop_count, 32'd1);
`endif

    // Alternating backpressure on a 16-beat packet
    base = n_out;
    send_pkt(32'h0307_0080, 16, 8'hFF, 32'h0703_0080, 1'b1);
    begin
      int n;
      n = 0;
      while ((sb.size() != 0 || m_axis_tvalid) && n < 400) begin
        @(posedge clk); #1;
        m_axis_tready = ~m_axis_tready;
        n++;
      end
    end
    m_axis_tready = 1'b1;
    wait_drain("stall_drained");
    check("stall_beat_count", n_out - base, 16);

    // Header FIFO full: 16 outstanding packets block the 17th
    m_axis_tready = 1'b0;
    base = n_out;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] u;
      u = {8'(i + 1), 8'(i + 32), 16'(i + 1)};
      send_pkt(u, 1, 8'hF0, swap_ports(u), 1'b1);
    end
    s_axis_tdata  = 64'h1717_1717_1717_1717;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("hdr_full_s_tready", s_axis_tready, 1'b0);
    end
    s_axis_tvalid = 1'b0;
    check("hdr_full_no_output", n_out - base, 0);
    m_axis_tready = 1'b1;
    send_pkt(32'h1102_0008, 1, 8'hF0, 32'h0211_0008, 1'b1);
    wait_drain("hdr_drained");
    check("hdr_beat_count", n_out - base, 17);
`ifdef LOOPBACK_STATS_EN
    check("stats_pkt_count", pkt_count, 32'd25);
    check("stats_drop_count", drop_count, 32'd1);
`endif

    // Reset with a committed-but-stalled packet and a partial packet in flight
    m_axis_tready = 1'b0;
    send_pkt(32'h090A_0010, 2, 8'hFF, 32'h0A09_0010, 1'b0);
    for (int i = 0; i < 3; i++)
      send_beat({$urandom, $urandom}, 8'hFF, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_m_tvalid", m_axis_tvalid, 1'b0);
    check("midrst_m_tdata",  m_axis_tdata,  64'h0);
    check("midrst_m_tuser",  m_axis_tuser,  128'h0);
    check("midrst_s_tready", s_axis_tready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    base = n_out;
    @(posedge clk); #1;
    send_pkt(32'h0201_0010, 2, 8'h3F, 32'h0102_0010, 1'b1);
    wait_drain("post_rst_drained");
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_beat_count", n_out - base, 2);
`ifdef LOOPBACK_STATS_EN
    check("post_rst_pkt_count", pkt_count, 32'd1);
    check("post_rst_drop_count", drop_count, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
